mul_share_arbiter: RTL and testbench

//  Shares one sequential multiplier (valid/ready operand port, valid/ready result port) among
//  NUM_REQ requesters. Round-robin arbitration; one transaction in flight at a time; each result
//  is returned only to the requester that issued it. Sits between client blocks and the multiplier.

---
 rtl/mul_arb_pkg.sv | 10 +
 rtl/rr_picker.sv | 29 ++
 rtl/mul_share_arbiter.sv | 115 +++++++++++
 tb/tb_mul_share_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i, wrapping.
module rr_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic               any_req_o,
  output logic [IDW-1:0]     winner_o
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    any_req_o = |req_i;
    winner_o  = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_i) + int'(k)) % int'(NUM_REQ));
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one valid/ready multiplier among NUM_REQ requesters, one transaction in flight,
// round-robin grant, result routed back only to the issuing requester.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 16,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     mul_src_valid,
  input  logic                     mul_src_ready,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_dest_valid,
  output logic                     mul_dest_ready,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] grant_inc;
  logic           any_req;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  assign grant_inc    = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign resp_product = mul_product;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    req_ready      = '0;
    resp_valid     = '0;
    mul_src_valid  = 1'b0;
    mul_a          = '0;
    mul_b          = '0;
    mul_dest_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_src_valid      = req_valid[grant_q];
        mul_a              = a_arr[grant_q];
        mul_b              = b_arr[grant_q];
        req_ready[grant_q] = mul_src_ready;
        if (req_valid[grant_q] && mul_src_ready) begin
          state_d = BUSY;
        end else if (!req_valid[grant_q]) begin
          // Withdrawn request: abandon without advancing the round-robin pointer.
          state_d = IDLE;
          grant_d = '0;
        end
      end
      BUSY: begin
        resp_valid[grant_q] = mul_dest_valid;
        mul_dest_ready      = resp_ready[grant_q];
        if (mul_dest_valid && resp_ready[grant_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = grant_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small signed-multiplier model behind it.
module tb_mul_share_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned LAT     = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     mul_src_valid;
  logic                     mul_src_ready;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_dest_valid;
  logic                     mul_dest_ready;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     busy;
  logic [1:0]               grant_id;

  int tests;
  int fails;

  // Multiplier model state and bench controls
  logic                 src_rdy_en;
  logic                 spurious;
  logic [2*WIDTH-1:0]   spurious_prod;
  logic                 m_busy;
  logic                 m_dv;
  logic [3:0]           m_cnt;
  logic [2*WIDTH-1:0]   m_prod;

  assign mul_src_ready  = src_rdy_en & ~m_busy;
  assign mul_dest_valid = m_dv | spurious;
  assign mul_product    = m_dv ? m_prod : spurious_prod;

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_product   (resp_product),
    .mul_src_valid  (mul_src_valid),
    .mul_src_ready  (mul_src_ready),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_dest_valid (mul_dest_valid),
    .mul_dest_ready (mul_dest_ready),
    .mul_product    (mul_product),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_dv   <= 1'b0;
      m_cnt  <= '0;
      m_prod <= '0;
    end else if (!m_busy && mul_src_valid && mul_src_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'(LAT);
      m_prod <= $signed(mul_a) * $signed(mul_b);
    end else if (m_busy && !m_dv) begin
      if (m_cnt == 0) m_dv <= 1'b1;
      else            m_cnt <= m_cnt - 1'b1;
    end else if (m_dv && mul_dest_ready) begin
      m_dv   <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (mul_src_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (resp_valid !== '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, grant_id, req_ready, resp_valid, mul_src_valid, mul_dest_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b grant=%0d req_ready=%b resp_valid=%b src_v=%b dest_r=%b, required all 0",
               busy, grant_id, req_ready, resp_valid, mul_src_valid, mul_dest_ready);
    end
    tests++;
    if ({mul_a, mul_b} !== '0) begin
      fails++;
      $display("FAIL reset_operands: mul_a=%h mul_b=%h, required 0", mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    bit ok;
    set_ops(2, 16'd7, 16'hFFFD);
    req_valid = 4'b0100;
    tick();
    tests++;
    if (grant_id !== 2'd2 || mul_src_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: grant=%0d src_v=%b busy=%b, required 2 1 1", grant_id, mul_src_valid, busy);
    end
    tests++;
    if (mul_a !== 16'd7 || mul_b !== 16'hFFFD || req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL single_operands: a=%h b=%h req_ready=%b, required 0007 fffd 0100", mul_a, mul_b, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    wait_resp(ok);
    tests++;
    if (!ok || resp_valid !== 4'b0100 || resp_product !== 32'hFFFFFFEB || mul_dest_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_resp: ok=%b resp_valid=%b product=%h dest_r=%b, required 1 0100 ffffffeb 1",
               ok, resp_valid, resp_product, mul_dest_ready);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL single_done: busy=%b grant=%0d, required 0 0", busy, grant_id);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [31:0] exp_prod [4];
    exp_prod[0] = 32'd10;
    exp_prod[1] = 32'd18;
    exp_prod[2] = 32'd28;
    exp_prod[3] = 32'd40;
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 2), 16'(i + 5));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_issue(ok);
      tests++;
      if (!ok || grant_id !== 2'(k % 4)) begin
        fails++;
        $display("FAIL fair_grant[%0d]: ok=%b grant=%0d, required %0d", k, ok, grant_id, k % 4);
      end
      tick();
      wait_resp(ok);
      tests++;
      if (!ok || resp_valid !== 4'(1 << (k % 4)) || resp_product !== exp_prod[k % 4]) begin
        fails++;
        $display("FAIL fair_resp[%0d]: ok=%b resp_valid=%b product=%0d, required %b %0d",
                 k, ok, resp_valid, resp_product, 4'(1 << (k % 4)), exp_prod[k % 4]);
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_back_pressure();
    bit ok;
    set_ops(1, 16'd9, 16'd11);
    set_ops(3, 16'd4, 16'd6);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    wait_issue(ok);
    tests++;
    if (!ok || grant_id !== 2'd1) begin
      fails++;
      $display("FAIL bp_grant1: ok=%b grant=%0d, required 1", ok, grant_id);
    end
    tick();
    req_valid = 4'b1000;
    wait_resp(ok);
    for (int c = 0; c < 10; c++) begin
      tests++;
      if (!ok || resp_valid !== 4'b0010 || resp_product !== 32'd99 || mul_dest_ready !== 1'b0 ||
          grant_id !== 2'd1 || req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold[%0d]: resp_valid=%b product=%0d dest_r=%b grant=%0d req_ready=%b, required 0010 99 0 1 0000",
                 c, resp_valid, resp_product, mul_dest_ready, grant_id, req_ready);
      end
      tick();
    end
    resp_ready = 4'b1111;
    #1;
    tests++;
    if (mul_dest_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: dest_r=%b, required 1", mul_dest_ready);
    end
    tick();
    tick();
    tests++;
    if (grant_id !== 2'd3 || mul_src_valid !== 1'b1 || mul_a !== 16'd4) begin
      fails++;
      $display("FAIL bp_grant3: grant=%0d src_v=%b a=%0d, required 3 1 4", grant_id, mul_src_valid, mul_a);
    end
    tick();
    req_valid = 4'b0000;
    wait_resp(ok);
    tests++;
    if (!ok || resp_valid !== 4'b1000 || resp_product !== 32'd24) begin
      fails++;
      $display("FAIL bp_resp3: ok=%b resp_valid=%b product=%0d, required 1000 24", ok, resp_valid, resp_product);
    end
    tick();
  endtask

  task automatic test_withdraw();
    bit ok;
    set_ops(0, 16'd5, 16'd5);
    set_ops(1, 16'd2, 16'd2);
    src_rdy_en = 1'b0;
    req_valid  = 4'b0001;
    wait_issue(ok);
    tests++;
    if (!ok || grant_id !== 2'd0 || req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL wd_issue: ok=%b grant=%0d req_ready=%b, required 0 0000", ok, grant_id, req_ready);
    end
    req_valid = 4'b0000;
    tick();
    tests++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL wd_idle: busy=%b grant=%0d, required 0 0", busy, grant_id);
    end
    src_rdy_en = 1'b1;
    req_valid  = 4'b0011;
    tick();
    tests++;
    if (grant_id !== 2'd0 || mul_a !== 16'd5 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL wd_regrant: grant=%0d a=%0d req_ready=%b, required 0 5 0001", grant_id, mul_a, req_ready);
    end
    req_valid = 4'b0000;
    do_reset();
  endtask

  task automatic test_spurious();
    spurious      = 1'b1;
    spurious_prod = 32'd123;
    #1;
    tests++;
    if (resp_valid !== 4'b0000 || mul_dest_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL spurious_now: resp_valid=%b dest_r=%b busy=%b, required 0000 0 0", resp_valid, mul_dest_ready, busy);
    end
    tick();
    tests++;
    if (resp_valid !== 4'b0000 || mul_dest_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL spurious_next: resp_valid=%b dest_r=%b busy=%b, required 0000 0 0", resp_valid, mul_dest_ready, busy);
    end
    spurious = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    set_ops(0, 16'd1, 16'd1);
    set_ops(2, 16'd3, 16'd3);
    set_ops(3, 16'd8, 16'd8);
    resp_ready = 4'b1011;
    req_valid  = 4'b0100;
    wait_issue(ok);
    tick();
    req_valid = 4'b0000;
    wait_resp(ok);
    tests++;
    if (!ok || resp_valid !== 4'b0100 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_setup: ok=%b resp_valid=%b busy=%b, required 0100 1", ok, resp_valid, busy);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || req_ready !== 4'b0000 || resp_valid !== 4'b0000 || grant_id !== 2'd0 ||
        mul_dest_ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_cleared: busy=%b req_ready=%b resp_valid=%b grant=%0d dest_r=%b, required all 0",
               busy, req_ready, resp_valid, grant_id, mul_dest_ready);
    end
    rst        = 1'b1;
    resp_ready = 4'b1111;
    req_valid  = 4'b1001;
    tick();
    tests++;
    if (grant_id !== 2'd0 || mul_a !== 16'd1) begin
      fails++;
      $display("FAIL rmid_rrptr: grant=%0d a=%0d, required 0 1", grant_id, mul_a);
    end
    req_valid = 4'b0000;
    do_reset();
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b0;
    req_valid     = '0;
    req_a         = '0;
    req_b         = '0;
    resp_ready    = '1;
    src_rdy_en    = 1'b1;
    spurious      = 1'b0;
    spurious_prod = '0;
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_single();
    test_fairness();
    test_back_pressure();
    test_withdraw();
    test_spurious();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
